// File: rtl/coin_credit_ctrl_pkg.sv
// Shared vending-machine definitions: coin denominations, controller states and coin legality.
package coin_credit_ctrl_pkg;

    localparam logic [3:0] COIN_1  = 4'd1;
    localparam logic [3:0] COIN_5  = 4'd5;
    localparam logic [3:0] COIN_10 = 4'd10;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCollect = 2'd1,
        StVend    = 2'd2,
        StChange  = 2'd3
    } state_e;

    function automatic logic coin_is_legal(input logic [3:0] value);
        return (value == COIN_1) || (value == COIN_5) || (value == COIN_10);
    endfunction

endpackage

// File: rtl/coin_credit_ctrl_change_coin_pick.sv
// Greedy change selector: largest coin not exceeding the remaining credit.
module coin_credit_ctrl_change_coin_pick
    import coin_credit_ctrl_pkg::*;
#(
    parameter int unsigned CREDIT_W = 8
) (
    input  logic [CREDIT_W-1:0] credit,
    output logic [3:0]          coin
);

    always_comb begin
        if (credit >= CREDIT_W'(COIN_10)) begin
            coin = COIN_10;
        end else if (credit >= CREDIT_W'(COIN_5)) begin
            coin = COIN_5;
        end else begin
            coin = COIN_1;
        end
    end

endmodule

// File: rtl/coin_credit_ctrl.sv
// Vending credit controller: coin intake, product selection, vend pulse and greedy change payout.
module coin_credit_ctrl
    import coin_credit_ctrl_pkg::*;
#(
    parameter int unsigned CREDIT_W   = 8,
    parameter int unsigned MAX_CREDIT = 200
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid,
    input  logic [3:0]          coin_value,
    output logic                coin_ready,
    output logic                coin_reject,
    input  logic                sel_valid,
    input  logic [CREDIT_W-1:0] sel_price,
    output logic                sel_nack,
    input  logic                cancel,
    output logic                vend_pulse,
    output logic [CREDIT_W-1:0] credit,
    output logic                chg_valid,
    output logic [3:0]          chg_coin,
    input  logic                chg_ready,
    output logic                busy
);

    state_e              state;
    logic                coin_fire;
    logic                coin_ok;
    logic [CREDIT_W:0]   coin_sum;
    logic                sel_ok;
    logic [CREDIT_W-1:0] coin_add;
    logic [CREDIT_W-1:0] price_sub;
    logic [CREDIT_W-1:0] credit_d;
    logic [3:0]          pick_coin;

    assign coin_ready = (state == StIdle) || (state == StCollect);
    assign busy       = (state == StVend) || (state == StChange);

    // Carry bit only feeds the ceiling compare.
    assign coin_fire = coin_valid && coin_ready;
    assign coin_sum  = {1'b0, credit} + (CREDIT_W + 1)'(coin_value);
    assign coin_ok   = coin_fire && coin_is_legal(coin_value) &&
                       (coin_sum <= (CREDIT_W + 1)'(MAX_CREDIT));

    // Selection is judged against the pre-coin credit.
    assign sel_ok    = (sel_price != '0) && (credit >= sel_price);
    assign coin_add  = coin_ok ? CREDIT_W'(coin_value) : '0;
    assign price_sub = (state == StCollect && !cancel && sel_valid && sel_ok) ? sel_price : '0;

    always_comb begin
        credit_d = credit;
        case (state)
            StIdle, StCollect: credit_d = credit + coin_add - price_sub;
            StChange: begin
                if (chg_ready) begin
                    credit_d = credit - CREDIT_W'(chg_coin);
                end
            end
            default: ;
        endcase
    end

    coin_credit_ctrl_change_coin_pick #(
        .CREDIT_W(CREDIT_W)
    ) u_pick (
        .credit(credit_d),
        .coin  (pick_coin)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            credit      <= '0;
            coin_reject <= 1'b0;
            sel_nack    <= 1'b0;
            vend_pulse  <= 1'b0;
            chg_valid   <= 1'b0;
            chg_coin    <= '0;
        end else begin
            credit      <= credit_d;
            coin_reject <= coin_fire && !coin_ok;
            sel_nack    <= 1'b0;
            vend_pulse  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (sel_valid) begin
                        sel_nack <= 1'b1;
                    end
                    if (coin_ok) begin
                        state <= StCollect;
                    end
                end
                StCollect: begin
                    if (cancel) begin
                        state     <= StChange;
                        chg_valid <= 1'b1;
                        chg_coin  <= pick_coin;
                    end else if (sel_valid) begin
                        if (sel_ok) begin
                            state      <= StVend;
                            vend_pulse <= 1'b1;
                        end else begin
                            sel_nack <= 1'b1;
                        end
                    end
                end
                StVend: begin
                    if (credit != '0) begin
                        state     <= StChange;
                        chg_valid <= 1'b1;
                        chg_coin  <= pick_coin;
                    end else begin
                        state <= StIdle;
                    end
                end
                StChange: begin
                    // Coin is only re-picked after a handshake, so it holds while stalled.
                    if (chg_ready) begin
                        if (credit_d == '0) begin
                            state     <= StIdle;
                            chg_valid <= 1'b0;
                            chg_coin  <= '0;
                        end else begin
                            chg_coin <= pick_coin;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_coin_credit_ctrl.sv
// Directed self-checking bench for coin_credit_ctrl.
module tb_coin_credit_ctrl;

    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          coin_valid = 1'b0;
    logic [3:0]    coin_value = '0;
    logic          coin_ready;
    logic          coin_reject;
    logic          sel_valid = 1'b0;
    logic [CW-1:0] sel_price = '0;
    logic          sel_nack;
    logic          cancel = 1'b0;
    logic          vend_pulse;
    logic [CW-1:0] credit;
    logic          chg_valid;
    logic [3:0]    chg_coin;
    logic          chg_ready = 1'b0;
    logic          busy;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    coin_credit_ctrl #(
        .CREDIT_W  (CW),
        .MAX_CREDIT(200)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .coin_valid (coin_valid),
        .coin_value (coin_value),
        .coin_ready (coin_ready),
        .coin_reject(coin_reject),
        .sel_valid  (sel_valid),
        .sel_price  (sel_price),
        .sel_nack   (sel_nack),
        .cancel     (cancel),
        .vend_pulse (vend_pulse),
        .credit     (credit),
        .chg_valid  (chg_valid),
        .chg_coin   (chg_coin),
        .chg_ready  (chg_ready),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic insert(input logic [3:0] v);
        coin_valid = 1'b1;
        coin_value = v;
        step();
        coin_valid = 1'b0;
        coin_value = '0;
    endtask

    // Pays out everything with chg_ready high and checks the total handed out.
    task automatic drain(input string tag, input int exp_total);
        int total = 0;
        int cyc = 0;
        chg_ready = 1'b1;
        while (chg_valid && cyc < 300) begin
            total += int'(chg_coin);
            step();
            cyc++;
        end
        check({tag, "_timeout"}, 32'(chg_valid), 32'd0);
        check({tag, "_total"}, 32'(total), 32'(exp_total));
        check({tag, "_credit"}, 32'(credit), 32'd0);
        check({tag, "_idle"}, 32'(coin_ready), 32'd1);
    endtask

    initial begin
        int exp_seq[5];

        // Reset
        step();
        check("rst_credit", 32'(credit), 32'd0);
        check("rst_chg_valid", 32'(chg_valid), 32'd0);
        check("rst_chg_coin", 32'(chg_coin), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_vend", 32'(vend_pulse), 32'd0);
        check("rst_coin_ready", 32'(coin_ready), 32'd1);
        rst_n = 1'b1;
        step();

        // Selection in IDLE is refused
        sel_valid = 1'b1;
        sel_price = 8'd5;
        step();
        sel_valid = 1'b0;
        check("idle_sel_nack", 32'(sel_nack), 32'd1);
        check("idle_sel_credit", 32'(credit), 32'd0);

        // 1: coins 5,10,1 then illegal 3
        insert(4'd5);
        check("t1_c5", 32'(credit), 32'd5);
        check("t1_rej5", 32'(coin_reject), 32'd0);
        insert(4'd10);
        check("t1_c10", 32'(credit), 32'd15);
        insert(4'd1);
        check("t1_c1", 32'(credit), 32'd16);
        check("t1_rej1", 32'(coin_reject), 32'd0);
        insert(4'd3);
        check("t1_rej3", 32'(coin_reject), 32'd1);
        check("t1_c3", 32'(credit), 32'd16);
        step();
        check("t1_rej_pulse_end", 32'(coin_reject), 32'd0);

        // 2: vend price 12 from 16, change 1,1,1,1
        chg_ready = 1'b1;
        sel_valid = 1'b1;
        sel_price = 8'd12;
        step();
        sel_valid = 1'b0;
        check("t2_vend", 32'(vend_pulse), 32'd1);
        check("t2_credit", 32'(credit), 32'd4);
        check("t2_busy", 32'(busy), 32'd1);
        check("t2_coin_ready", 32'(coin_ready), 32'd0);
        step();
        check("t2_vend_end", 32'(vend_pulse), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("t2_chg_valid", 32'(chg_valid), 32'd1);
            check("t2_chg_coin", 32'(chg_coin), 32'd1);
            step();
        end
        check("t2_done_valid", 32'(chg_valid), 32'd0);
        check("t2_done_busy", 32'(busy), 32'd0);
        check("t2_done_credit", 32'(credit), 32'd0);

        // 3: credit 27, cancel, stalled first coin
        chg_ready = 1'b0;
        insert(4'd10);
        insert(4'd10);
        insert(4'd5);
        insert(4'd1);
        insert(4'd1);
        check("t3_credit", 32'(credit), 32'd27);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t3_stall_coin", 32'(chg_coin), 32'd10);
            check("t3_stall_credit", 32'(credit), 32'd27);
            step();
        end
        exp_seq = '{10, 10, 5, 1, 1};
        chg_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t3_seq_valid", 32'(chg_valid), 32'd1);
            check("t3_seq_coin", 32'(chg_coin), 32'(exp_seq[i]));
            step();
        end
        check("t3_end_valid", 32'(chg_valid), 32'd0);
        check("t3_end_credit", 32'(credit), 32'd0);

        // 4: ceiling
        for (int i = 0; i < 19; i++) insert(4'd10);
        insert(4'd5);
        check("t4_195", 32'(credit), 32'd195);
        insert(4'd10);
        check("t4_ovf_rej", 32'(coin_reject), 32'd1);
        check("t4_ovf_credit", 32'(credit), 32'd195);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        drain("t4_drain195", 195);
        for (int i = 0; i < 19; i++) insert(4'd10);
        check("t4_190", 32'(credit), 32'd190);
        insert(4'd10);
        check("t4_200", 32'(credit), 32'd200);
        check("t4_200_rej", 32'(coin_reject), 32'd0);
        insert(4'd1);
        check("t4_201_rej", 32'(coin_reject), 32'd1);
        check("t4_201_credit", 32'(credit), 32'd200);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        drain("t4_drain200", 200);

        // 5: same-cycle coin with selection / cancel
        insert(4'd5);
        insert(4'd1);
        insert(4'd1);
        check("t5_7", 32'(credit), 32'd7);
        coin_valid = 1'b1;
        coin_value = 4'd5;
        sel_valid  = 1'b1;
        sel_price  = 8'd10;
        step();
        coin_valid = 1'b0;
        sel_valid  = 1'b0;
        check("t5_nack", 32'(sel_nack), 32'd1);
        check("t5_credit12", 32'(credit), 32'd12);
        check("t5_no_vend", 32'(vend_pulse), 32'd0);
        sel_valid = 1'b1;
        sel_price = 8'd0;
        step();
        sel_valid = 1'b0;
        check("t5_price0_nack", 32'(sel_nack), 32'd1);
        check("t5_price0_busy", 32'(busy), 32'd0);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        drain("t5_drain_a", 12);
        insert(4'd5);
        insert(4'd1);
        insert(4'd1);
        coin_valid = 1'b1;
        coin_value = 4'd5;
        cancel     = 1'b1;
        step();
        coin_valid = 1'b0;
        cancel     = 1'b0;
        check("t5_cancel_coin", 32'(chg_coin), 32'd10);
        drain("t5_drain_b", 12);

        // 6: async reset mid-CHANGE
        chg_ready = 1'b0;
        insert(4'd5);
        insert(4'd1);
        insert(4'd1);
        insert(4'd1);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        check("t6_chg_coin", 32'(chg_coin), 32'd5);
        check("t6_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_credit", 32'(credit), 32'd0);
        check("t6_rst_chg_valid", 32'(chg_valid), 32'd0);
        check("t6_rst_chg_coin", 32'(chg_coin), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("t6_idle_ready", 32'(coin_ready), 32'd1);
        check("t6_idle_credit", 32'(credit), 32'd0);
        check("t6_idle_chg", 32'(chg_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
